// File: rtl/pipeidex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipeidex_pkg                                                    |
// | Purpose  : Shared definitions for the ID/EX boundary: forward-select codes, |
// |            the execute-stage control bundle with its bubble value, and a    |
// |            register-match helper that ignores r0.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pipeidex_pkg;

  // Operand source selects, also exported on fwda/fwdb.
  localparam logic [1:0] FWD_RF     = 2'd0;  // register-file read
  localparam logic [1:0] FWD_EXALU  = 2'd1;  // ALU result of the instruction in EX
  localparam logic [1:0] FWD_MEMALU = 2'd2;  // ALU result of the instruction in MEM
  localparam logic [1:0] FWD_MEMMO  = 2'd3;  // load data of the instruction in MEM

  // The four controls that make an instruction architecturally visible.
  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
    logic jal;
  } ectrl_t;

  // A bubble writes nothing, reads nothing from memory, and links nothing.
  localparam ectrl_t BUBBLE_CTRL = 4'b0000;

  // True when a producer tag names the same non-zero register as a source.
  // r0 is hardwired to zero, so it never participates in forwarding or stalls.
  function automatic logic reg_hit(input logic [4:0] tag, input logic [4:0] src);
    return (tag != 5'd0) && (tag == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipefwd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipefwd                                                         |
// | Purpose  : Forwarding for one source operand. Picks the youngest producer  |
// |            of the source register (EX before MEM) and muxes the operand.   |
// | Ports    : i_src        source register number                            |
// |            i_dq         register-file read value                          |
// |            i_ern/i_ewreg/i_em2reg/i_ealu   EX-stage tag and ALU result    |
// |            i_mrn/i_mwreg/i_mm2reg/i_malu/i_mmo  MEM-stage tag and results  |
// |            o_fwd        select used (FWD_* encoding)                       |
// |            o_q          forwarded operand                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipefwd
  import pipeidex_pkg::*;
(
  input  logic [4:0]  i_src,
  input  logic [31:0] i_dq,
  input  logic [4:0]  i_ern,
  input  logic        i_ewreg,
  input  logic        i_em2reg,
  input  logic [31:0] i_ealu,
  input  logic [4:0]  i_mrn,
  input  logic        i_mwreg,
  input  logic        i_mm2reg,
  input  logic [31:0] i_malu,
  input  logic [31:0] i_mmo,
  output logic [1:0]  o_fwd,
  output logic [31:0] o_q
);

  logic w_ex_hit;
  logic w_mem_hit;

  // A load in EX has no data yet; that case is covered by the stall, so
  // only non-load EX producers are eligible for forwarding.
  assign w_ex_hit  = i_ewreg & ~i_em2reg & reg_hit(i_ern, i_src);
  assign w_mem_hit = i_mwreg & reg_hit(i_mrn, i_src);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_ex_hit) begin
      o_fwd = FWD_EXALU;
    end else if (w_mem_hit) begin
      o_fwd = i_mm2reg ? FWD_MEMMO : FWD_MEMALU;
    end
  end

  always_comb begin
    o_q = i_dq;
    case (o_fwd)
      FWD_EXALU:  o_q = i_ealu;
      FWD_MEMALU: o_q = i_malu;
      FWD_MEMMO:  o_q = i_mmo;
      default:    o_q = i_dq;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipeidex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipeidex                                                        |
// | Purpose  : Decode-to-execute boundary: operand forwarding, load-use hazard |
// |            detection, the ID/EX pipeline register and a stall counter.     |
// | Ports    : clock, reset      rising-edge clock, async active-high reset    |
// |            d*                 decoded ID-stage fields and controls          |
// |            drs_used/drt_used  instruction actually reads rs / rt           |
// |            dkill              squash the ID instruction (bubble)            |
// |            ern/ewreg_in/em2reg_in/ealu     EX-stage tag and result         |
// |            mrn/mwreg/mm2reg/malu/mmo       MEM-stage tag and results       |
// |            e*                 registered operands/controls for EX           |
// |            stall              hold PC and IF/ID (combinational)             |
// |            fwda/fwdb          forward selects (combinational)               |
// |            stall_cnt          saturating count of stall cycles              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipeidex
  import pipeidex_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  // ID stage
  input  logic        dwreg,
  input  logic        dm2reg,
  input  logic        dwmem,
  input  logic        daluimm,
  input  logic        dshift,
  input  logic        djal,
  input  logic [3:0]  daluc,
  input  logic [31:0] dqa,
  input  logic [31:0] dqb,
  input  logic [31:0] dimm,
  input  logic [31:0] dpc4,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic [4:0]  drn,
  input  logic        drs_used,
  input  logic        drt_used,
  input  logic        dkill,
  // EX stage write-back tag
  input  logic [4:0]  ern,
  input  logic        ewreg_in,
  input  logic        em2reg_in,
  input  logic [31:0] ealu,
  // MEM stage write-back tag
  input  logic [4:0]  mrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [31:0] malu,
  input  logic [31:0] mmo,
  // To EX stage
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic        ealuimm,
  output logic        eshift,
  output logic        ejal,
  output logic [3:0]  ealuc,
  output logic [31:0] ea,
  output logic [31:0] eb,
  output logic [31:0] eimm,
  output logic [31:0] epc4,
  output logic [4:0]  ern0,
  // Hazard / observation
  output logic        stall,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic [15:0] stall_cnt
);

  logic [31:0] w_fa;
  logic [31:0] w_fb;
  logic        w_stall;
  logic        w_bubble;

  ectrl_t      r_ctrl;
  logic        r_aluimm;
  logic        r_shift;
  logic [3:0]  r_aluc;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_imm;
  logic [31:0] r_pc4;
  logic [4:0]  r_rn;
  logic [15:0] r_stall_cnt;

  pipefwd u_fwd_a (
    .i_src    (drs),
    .i_dq     (dqa),
    .i_ern    (ern),
    .i_ewreg  (ewreg_in),
    .i_em2reg (em2reg_in),
    .i_ealu   (ealu),
    .i_mrn    (mrn),
    .i_mwreg  (mwreg),
    .i_mm2reg (mm2reg),
    .i_malu   (malu),
    .i_mmo    (mmo),
    .o_fwd    (fwda),
    .o_q      (w_fa)
  );

  pipefwd u_fwd_b (
    .i_src    (drt),
    .i_dq     (dqb),
    .i_ern    (ern),
    .i_ewreg  (ewreg_in),
    .i_em2reg (em2reg_in),
    .i_ealu   (ealu),
    .i_mrn    (mrn),
    .i_mwreg  (mwreg),
    .i_mm2reg (mm2reg),
    .i_malu   (malu),
    .i_mmo    (mmo),
    .o_fwd    (fwdb),
    .o_q      (w_fb)
  );

  // Load in EX whose destination is a source the ID instruction really reads:
  // the data only exists after MEM, so hold ID one cycle and let MEM forward it.
  assign w_stall = ewreg_in & em2reg_in &
                   ((drs_used & reg_hit(ern, drs)) | (drt_used & reg_hit(ern, drt)));

  assign w_bubble = w_stall | dkill;
  assign stall    = w_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ctrl   <= BUBBLE_CTRL;
      r_aluimm <= 1'b0;
      r_shift  <= 1'b0;
      r_aluc   <= 4'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_imm    <= 32'd0;
      r_pc4    <= 32'd0;
      r_rn     <= 5'd0;
    end else begin
      // Datapath fields load unconditionally; a bubble is made harmless
      // purely by clearing the state-changing controls.
      r_aluimm <= daluimm;
      r_shift  <= dshift;
      r_aluc   <= daluc;
      r_a      <= w_fa;
      r_b      <= w_fb;
      r_imm    <= dimm;
      r_pc4    <= dpc4;
      r_rn     <= drn;
      if (w_bubble) begin
        r_ctrl <= BUBBLE_CTRL;
      end else begin
        r_ctrl <= '{wreg: dwreg, m2reg: dm2reg, wmem: dwmem, jal: djal};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign ewreg     = r_ctrl.wreg;
  assign em2reg    = r_ctrl.m2reg;
  assign ewmem     = r_ctrl.wmem;
  assign ejal      = r_ctrl.jal;
  assign ealuimm   = r_aluimm;
  assign eshift    = r_shift;
  assign ealuc     = r_aluc;
  assign ea        = r_a;
  assign eb        = r_b;
  assign eimm      = r_imm;
  assign epc4      = r_pc4;
  assign ern0      = r_rn;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeidex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipeidex                                                     |
// | Purpose  : Scoreboard bench for pipeidex. Stimulus is applied on the       |
// |            falling edge; combinational expectations are checked shortly    |
// |            after, registered ones just after the following rising edge.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pipeidex;

  logic        clock = 1'b0;
  logic        reset;
  logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal;
  logic [3:0]  daluc;
  logic [31:0] dqa, dqb, dimm, dpc4;
  logic [4:0]  drs, drt, drn;
  logic        drs_used, drt_used, dkill;
  logic [4:0]  ern;
  logic        ewreg_in, em2reg_in;
  logic [31:0] ealu;
  logic [4:0]  mrn;
  logic        mwreg, mm2reg;
  logic [31:0] malu, mmo;
  logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
  logic [3:0]  ealuc;
  logic [31:0] ea, eb, eimm, epc4;
  logic [4:0]  ern0;
  logic        stall;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_cnt;

  pipeidex dut (
    .clock(clock), .reset(reset),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
    .dshift(dshift), .djal(djal), .daluc(daluc),
    .dqa(dqa), .dqb(dqb), .dimm(dimm), .dpc4(dpc4),
    .drs(drs), .drt(drt), .drn(drn),
    .drs_used(drs_used), .drt_used(drt_used), .dkill(dkill),
    .ern(ern), .ewreg_in(ewreg_in), .em2reg_in(em2reg_in), .ealu(ealu),
    .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .malu(malu), .mmo(mmo),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
    .eshift(eshift), .ejal(ejal), .ealuc(ealuc),
    .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0),
    .stall(stall), .fwda(fwda), .fwdb(fwdb), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  // Signal identifiers for the scoreboard
  localparam int S_EA = 0, S_EB = 1, S_EIMM = 2, S_EPC4 = 3, S_ERN0 = 4, S_EALUC = 5,
                 S_EWREG = 6, S_EM2REG = 7, S_EWMEM = 8, S_EJAL = 9, S_EALUIMM = 10,
                 S_ESHIFT = 11, S_STALL = 12, S_FWDA = 13, S_FWDB = 14, S_CNT = 15;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_EA:      return ea;
      S_EB:      return eb;
      S_EIMM:    return eimm;
      S_EPC4:    return epc4;
      S_ERN0:    return {27'd0, ern0};
      S_EALUC:   return {28'd0, ealuc};
      S_EWREG:   return {31'd0, ewreg};
      S_EM2REG:  return {31'd0, em2reg};
      S_EWMEM:   return {31'd0, ewmem};
      S_EJAL:    return {31'd0, ejal};
      S_EALUIMM: return {31'd0, ealuimm};
      S_ESHIFT:  return {31'd0, eshift};
      S_STALL:   return {31'd0, stall};
      S_FWDA:    return {30'd0, fwda};
      S_FWDB:    return {30'd0, fwdb};
      S_CNT:     return {16'd0, stall_cnt};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input exp_t e);
    logic [31:0] act;
    act = actual(e.sig);
    n_cmp++;
    if (act !== e.val) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", e.name, act, e.val, cyc);
    end
  endtask

  // Expected combinational value for the inputs just applied.
  task automatic exp_c(input string name, input int sig, input logic [31:0] val);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
    comb_q.push_back(e);
  endtask

  // Expected register value after the next rising edge.
  task automatic exp_r(input string name, input int sig, input logic [31:0] val);
    exp_t e;
    e.cyc = cyc + 1; e.sig = sig; e.val = val; e.name = name;
    reg_q.push_back(e);
  endtask

  // Registered-output monitor
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      while (reg_q.size() > 0 && reg_q[0].cyc <= cyc) check(reg_q.pop_front());
    end
  end

  // Combinational-output monitor
  initial begin
    forever begin
      @(negedge clock);
      #2;
      while (comb_q.size() > 0) check(comb_q.pop_front());
    end
  end

  task automatic idle();
    dwreg = 0; dm2reg = 0; dwmem = 0; daluimm = 0; dshift = 0; djal = 0;
    daluc = 0; dqa = 0; dqb = 0; dimm = 0; dpc4 = 0;
    drs = 0; drt = 0; drn = 0; drs_used = 0; drt_used = 0; dkill = 0;
    ern = 0; ewreg_in = 0; em2reg_in = 0; ealu = 0;
    mrn = 0; mwreg = 0; mm2reg = 0; malu = 0; mmo = 0;
  endtask

  // EX holds a load to r9 and ID reads r9 through rs.
  task automatic load_use_rs();
    ern = 5'd9; ewreg_in = 1; em2reg_in = 1;
    drs = 5'd9; drs_used = 1; dwreg = 1; drn = 5'd3;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // Reset holds every output at zero even with live ID inputs
    @(negedge clock);
    dqa = 32'h11; dwreg = 1; dwmem = 1; djal = 1; dm2reg = 1; dimm = 32'h55;
    exp_r("rst_ea", S_EA, 32'h0);
    exp_r("rst_ewreg", S_EWREG, 32'h0);
    exp_r("rst_ewmem", S_EWMEM, 32'h0);
    exp_r("rst_ejal", S_EJAL, 32'h0);
    exp_r("rst_em2reg", S_EM2REG, 32'h0);
    exp_r("rst_eimm", S_EIMM, 32'h0);
    exp_r("rst_cnt", S_CNT, 32'h0);

    // Release: first edge loads ID normally
    @(negedge clock);
    reset = 1'b0;
    idle();
    dqa = 32'h11; dqb = 32'h22; dwreg = 1; dimm = 32'h55; dpc4 = 32'h104;
    daluc = 4'hA; daluimm = 1; dshift = 1; drn = 5'd4; djal = 1;
    exp_c("rel_fwda", S_FWDA, 32'd0);
    exp_r("rel_ea", S_EA, 32'h11);
    exp_r("rel_eb", S_EB, 32'h22);
    exp_r("rel_ewreg", S_EWREG, 32'h1);
    exp_r("rel_eimm", S_EIMM, 32'h55);
    exp_r("rel_epc4", S_EPC4, 32'h104);
    exp_r("rel_ealuc", S_EALUC, 32'hA);
    exp_r("rel_ealuimm", S_EALUIMM, 32'h1);
    exp_r("rel_eshift", S_ESHIFT, 32'h1);
    exp_r("rel_ern0", S_ERN0, 32'h4);
    exp_r("rel_ejal", S_EJAL, 32'h1);

    // EX ALU forward
    @(negedge clock);
    idle();
    ern = 5'd5; ewreg_in = 1; ealu = 32'hAA; drs = 5'd5; dqa = 32'h99; dwreg = 1;
    exp_c("exfwd_fwda", S_FWDA, 32'd1);
    exp_c("exfwd_stall", S_STALL, 32'd0);
    exp_r("exfwd_ea", S_EA, 32'hAA);

    // EX beats MEM
    @(negedge clock);
    mrn = 5'd5; mwreg = 1; malu = 32'hBB;
    exp_c("expri_fwda", S_FWDA, 32'd1);
    exp_r("expri_ea", S_EA, 32'hAA);

    // MEM ALU forward once EX no longer writes
    @(negedge clock);
    ewreg_in = 0;
    exp_c("memalu_fwda", S_FWDA, 32'd2);
    exp_r("memalu_ea", S_EA, 32'hBB);

    // MEM load-data forward on rt
    @(negedge clock);
    idle();
    mrn = 5'd7; mwreg = 1; mm2reg = 1; mmo = 32'hCAFE; malu = 32'h1;
    drt = 5'd7; dqb = 32'h1234; dqa = 32'h4321;
    exp_c("memmo_fwdb", S_FWDB, 32'd3);
    exp_c("memmo_fwda", S_FWDA, 32'd0);
    exp_r("memmo_eb", S_EB, 32'hCAFE);
    exp_r("memmo_ea", S_EA, 32'h4321);

    // Load-use on rs: one stall, bubble, counter 1
    @(negedge clock);
    idle();
    load_use_rs();
    exp_c("lu_stall", S_STALL, 32'd1);
    exp_r("lu_ewreg", S_EWREG, 32'h0);
    exp_r("lu_cnt", S_CNT, 32'h1);

    // Next cycle: load in MEM, EX holds the bubble
    @(negedge clock);
    idle();
    mrn = 5'd9; mwreg = 1; mm2reg = 1; mmo = 32'hD00D;
    drs = 5'd9; drs_used = 1; dwreg = 1; drn = 5'd3;
    exp_c("lu2_stall", S_STALL, 32'd0);
    exp_c("lu2_fwda", S_FWDA, 32'd3);
    exp_r("lu2_ea", S_EA, 32'hD00D);
    exp_r("lu2_ewreg", S_EWREG, 32'h1);
    exp_r("lu2_ern0", S_ERN0, 32'h3);
    exp_r("lu2_cnt", S_CNT, 32'h1);

    // Same tags but rs not read: no stall
    @(negedge clock);
    idle();
    load_use_rs();
    drs_used = 0;
    exp_c("nouse_stall", S_STALL, 32'd0);
    exp_c("nouse_fwda", S_FWDA, 32'd0);
    exp_r("nouse_ewreg", S_EWREG, 32'h1);
    exp_r("nouse_cnt", S_CNT, 32'h1);

    // Load-use through rt
    @(negedge clock);
    idle();
    ern = 5'd9; ewreg_in = 1; em2reg_in = 1; drt = 5'd9; drt_used = 1; dwreg = 1;
    exp_c("lurt_stall", S_STALL, 32'd1);
    exp_r("lurt_ewreg", S_EWREG, 32'h0);
    exp_r("lurt_cnt", S_CNT, 32'h2);

    // r0 producer never stalls or forwards
    @(negedge clock);
    idle();
    ern = 5'd0; ewreg_in = 1; em2reg_in = 1; ealu = 32'h5;
    mrn = 5'd0; mwreg = 1; malu = 32'h6;
    drs = 5'd0; drs_used = 1; dqa = 32'h0; dwreg = 1;
    exp_c("r0_stall", S_STALL, 32'd0);
    exp_c("r0_fwda", S_FWDA, 32'd0);
    exp_r("r0_ewreg", S_EWREG, 32'h1);
    exp_r("r0_cnt", S_CNT, 32'h2);

    // Kill inserts a bubble
    @(negedge clock);
    idle();
    dkill = 1; dwreg = 1; dwmem = 1; djal = 1; dm2reg = 1;
    exp_c("kill_stall", S_STALL, 32'd0);
    exp_r("kill_ewreg", S_EWREG, 32'h0);
    exp_r("kill_ewmem", S_EWMEM, 32'h0);
    exp_r("kill_ejal", S_EJAL, 32'h0);
    exp_r("kill_em2reg", S_EM2REG, 32'h0);

    // Stall together with kill: single bubble, counter still counts
    @(negedge clock);
    idle();
    load_use_rs();
    dkill = 1; dwmem = 1;
    exp_c("sk_stall", S_STALL, 32'd1);
    exp_r("sk_ewreg", S_EWREG, 32'h0);
    exp_r("sk_ewmem", S_EWMEM, 32'h0);
    exp_r("sk_cnt", S_CNT, 32'h3);

    // Reset asserted mid-stall
    @(negedge clock);
    idle();
    load_use_rs();
    reset = 1'b1;
    exp_c("rstst_stall", S_STALL, 32'd1);
    exp_r("rstst_cnt", S_CNT, 32'h0);
    exp_r("rstst_ewreg", S_EWREG, 32'h0);

    @(negedge clock);
    reset = 1'b0;
    idle();
    dqa = 32'h77; dwreg = 1;
    exp_r("rstrel_ea", S_EA, 32'h77);
    exp_r("rstrel_ewreg", S_EWREG, 32'h1);
    exp_r("rstrel_cnt", S_CNT, 32'h0);

    // Saturation: hold the hazard long enough to wrap a 16-bit counter
    @(negedge clock);
    idle();
    load_use_rs();
    repeat (65540) @(negedge clock);
    exp_c("sat_stall", S_STALL, 32'd1);
    exp_r("sat_cnt", S_CNT, 32'hFFFF);

    @(negedge clock);
    idle();
    exp_r("sat_hold_cnt", S_CNT, 32'hFFFF);

    // Drain with a bounded wait
    repeat (4) @(negedge clock);
    while (comb_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: never checked (combinational queue)", comb_q[0].name);
      void'(comb_q.pop_front());
    end
    while (reg_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: never checked (register queue)", reg_q[0].name);
      void'(reg_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
